// File: rtl/ohs_boost_pkg.sv
// ---------------------------------------------------------------------------
// ohs_boost_pkg
// Shared types and helpers for the N-phase interleaved boost model.
//   state_t      : step sequencer states (IDLE, PHASE, LOAD, CAP)
//   phase_idx_w  : width of the leg index, $clog2(n) but never below 1
//   q_one        : value of 1.0 in a Q-format with q fractional bits
//   sat_w        : clamp a wide signed value into a w-bit signed range
// ---------------------------------------------------------------------------
package ohs_boost_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PHASE = 2'd1,
      LOAD  = 2'd2,
      CAP   = 2'd3
   } state_t;

   function automatic int phase_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic signed [63:0] q_one(input int q);
      return 64'sd1 <<< q;
   endfunction

   // Result is meaningful in its low w bits; callers size-cast to w.
   function automatic logic signed [63:0] sat_w(input logic signed [127:0] x,
                                                input int w);
      logic signed [127:0] mx;
      logic signed [127:0] mn;
      mx = (128'sd1 <<< (w - 1)) - 128'sd1;
      mn = -mx - 128'sd1;
      if (x > mx) begin
         return mx[63:0];
      end else if (x < mn) begin
         return mn[63:0];
      end else begin
         return x[63:0];
      end
   endfunction

endpackage

// File: rtl/ohs_boost_nphase_l1_fixmul.sv
// ---------------------------------------------------------------------------
// ohs_fixmul_sat
// Combinational Q-format multiply: full 2W-bit signed product, arithmetic
// shift right by Q, saturate to W bits.
//   a, b : W-bit signed operands (Q format)
//   p    : W-bit signed saturated result (Q format)
// ---------------------------------------------------------------------------
module ohs_fixmul_sat
   import ohs_boost_pkg::*;
#(
   parameter int W = 32,
   parameter int Q = 22
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [W-1:0] p
);

   logic signed [2*W-1:0] prod_s;

   // Full-precision product, rescale, then clamp into range
   always_comb begin
      prod_s = (2*W)'(a) * (2*W)'(b);
      p      = W'(sat_w(128'(prod_s >>> Q), W));
   end

endmodule

// File: rtl/ohs_boost_nphase_l1.sv
// ---------------------------------------------------------------------------
// ohs_boost_nphase_l1
// N-phase interleaved boost converter, forward-Euler step per ce pulse.
// Legs are stepped one per cycle through a single shared multiplier,
// then the load current and the output capacitor are updated.
//   aclk, reset : clock, synchronous active-high reset
//   ce          : starts one integration step (ignored while busy)
//   kL, kC, kR  : dt/L, dt/C, 1/R (Q format), snapshotted at step start
//   vdc         : input voltage (Q format), snapshotted at step start
//   S_pwm       : per-leg switch state, snapshotted at step start
//   iL, vL      : packed per-leg current / voltage, leg p at [p*W +: W]
//   iC, vC      : capacitor current / voltage
//   iLoad       : load current
//   busy, done  : step in progress / one-cycle outputs-updated pulse
//   overrun     : sticky, ce seen while busy
// Optional build macro OHS_BOOST_DCM_EN: diode blocking, negative leg
// current is clamped to 0 and the leg voltage reported as 0.
// ---------------------------------------------------------------------------
module ohs_boost_nphase_l1
   import ohs_boost_pkg::*;
#(
   parameter int MODEL_DATA_WIDTH = 32,
   parameter int MODEL_Q_WIDTH    = 22,
   parameter int N_PHASES         = 4
) (
   input  logic                                  aclk,
   input  logic                                  reset,
   input  logic                                  ce,
   input  logic signed [MODEL_DATA_WIDTH-1:0]    kL,
   input  logic signed [MODEL_DATA_WIDTH-1:0]    kC,
   input  logic signed [MODEL_DATA_WIDTH-1:0]    kR,
   input  logic signed [MODEL_DATA_WIDTH-1:0]    vdc,
   input  logic        [N_PHASES-1:0]            S_pwm,
   output logic [N_PHASES*MODEL_DATA_WIDTH-1:0]  iL,
   output logic [N_PHASES*MODEL_DATA_WIDTH-1:0]  vL,
   output logic signed [MODEL_DATA_WIDTH-1:0]    iC,
   output logic signed [MODEL_DATA_WIDTH-1:0]    vC,
   output logic signed [MODEL_DATA_WIDTH-1:0]    iLoad,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  overrun
);

   localparam int W  = MODEL_DATA_WIDTH;
   localparam int Q  = MODEL_Q_WIDTH;
   localparam int PW = phase_idx_w(N_PHASES);

   state_t                state_r;
   logic [PW-1:0]         p_r;
   logic signed [W-1:0]   kl_r, kc_r, kr_r, vdc_r, iload_r;
   logic [N_PHASES-1:0]   s_r;
   logic signed [W-1:0]   il_st_r [N_PHASES];
   logic signed [W-1:0]   vl_st_r [N_PHASES];

   logic signed [W-1:0]   mul_a_s, mul_b_s, mul_p_s;
   logic signed [W-1:0]   vl_raw_s, il_upd_s, il_new_s, vl_new_s;
   logic signed [W-1:0]   ic_s, vc_new_s;
   logic signed [W+3:0]   isum_s;

   ohs_fixmul_sat #(.W(W), .Q(Q)) u_mul (
      .a (mul_a_s),
      .b (mul_b_s),
      .p (mul_p_s)
   );

   // Leg update for the leg currently selected by p_r. vC is only written
   // at the end of a step, so vC itself serves as the step's vC_old.
   always_comb begin
      if (s_r[p_r]) begin
         vl_raw_s = vdc_r;
      end else begin
         vl_raw_s = W'(sat_w(128'(vdc_r) - 128'(vC), W));
      end
      il_upd_s = W'(sat_w(128'(il_st_r[p_r]) + 128'(mul_p_s), W));
`ifdef OHS_BOOST_DCM_EN
      if (il_upd_s < 0) begin
         il_new_s = {W{1'b0}};
         vl_new_s = {W{1'b0}};
      end else begin
         il_new_s = il_upd_s;
         vl_new_s = vl_raw_s;
      end
`else
      il_new_s = il_upd_s;
      vl_new_s = vl_raw_s;
`endif
   end

   // Capacitor current from switch-off legs (post-update) minus load
   always_comb begin
      isum_s = {(W+4){1'b0}};
      for (int i = 0; i < N_PHASES; i++) begin
         if (!s_r[i]) begin
            isum_s = isum_s + (W+4)'(il_st_r[i]);
         end else begin
            isum_s = isum_s;
         end
      end
      isum_s   = isum_s - (W+4)'(iload_r);
      ic_s     = W'(sat_w(128'(isum_s), W));
      vc_new_s = W'(sat_w(128'(vC) + 128'(mul_p_s), W));
   end

   // Shared multiplier operand select by sequencer state
   always_comb begin
      mul_a_s = {W{1'b0}};
      mul_b_s = {W{1'b0}};
      case (state_r)
         PHASE: begin
            mul_a_s = kl_r;
            mul_b_s = vl_raw_s;
         end
         LOAD: begin
            mul_a_s = kr_r;
            mul_b_s = vC;
         end
         CAP: begin
            mul_a_s = kc_r;
            mul_b_s = ic_s;
         end
         default: begin
            mul_a_s = {W{1'b0}};
            mul_b_s = {W{1'b0}};
         end
      endcase
   end

   // Step sequencer, model state and registered outputs
   always_ff @(posedge aclk) begin
      if (reset) begin
         state_r <= IDLE;
         p_r     <= {PW{1'b0}};
         kl_r    <= {W{1'b0}};
         kc_r    <= {W{1'b0}};
         kr_r    <= {W{1'b0}};
         vdc_r   <= {W{1'b0}};
         iload_r <= {W{1'b0}};
         s_r     <= {N_PHASES{1'b0}};
         for (int i = 0; i < N_PHASES; i++) begin
            il_st_r[i] <= {W{1'b0}};
            vl_st_r[i] <= {W{1'b0}};
         end
         iL      <= {(N_PHASES*W){1'b0}};
         vL      <= {(N_PHASES*W){1'b0}};
         iC      <= {W{1'b0}};
         vC      <= {W{1'b0}};
         iLoad   <= {W{1'b0}};
         busy    <= 1'b0;
         done    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         done <= 1'b0;
         if (ce && (state_r != IDLE)) begin
            overrun <= 1'b1;
         end
         case (state_r)
            IDLE: begin
               if (ce) begin
                  kl_r    <= kL;
                  kc_r    <= kC;
                  kr_r    <= kR;
                  vdc_r   <= vdc;
                  s_r     <= S_pwm;
                  p_r     <= {PW{1'b0}};
                  busy    <= 1'b1;
                  state_r <= PHASE;
               end
            end
            PHASE: begin
               il_st_r[p_r] <= il_new_s;
               vl_st_r[p_r] <= vl_new_s;
               if (p_r == PW'(N_PHASES - 1)) begin
                  state_r <= LOAD;
               end else begin
                  p_r <= p_r + PW'(1);
               end
            end
            LOAD: begin
               iload_r <= mul_p_s;
               state_r <= CAP;
            end
            CAP: begin
               for (int i = 0; i < N_PHASES; i++) begin
                  iL[i*W +: W] <= il_st_r[i];
                  vL[i*W +: W] <= vl_st_r[i];
               end
               iC      <= ic_s;
               vC      <= vc_new_s;
               iLoad   <= iload_r;
               done    <= 1'b1;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ohs_boost_nphase_l1.sv
// ---------------------------------------------------------------------------
// tb_ohs_boost_nphase_l1
// Directed stimulus with hand-computed expectations pushed into a queue;
// a monitor pops and compares whenever done is presented.
// Honours OHS_BOOST_DCM_EN for the diode-blocking expectations.
// ---------------------------------------------------------------------------
module tb_ohs_boost_nphase_l1;

   localparam int W = 32;
   localparam int Q = 22;
   localparam int N = 4;

   logic           aclk = 1'b0;
   logic           reset, ce;
   logic [W-1:0]   kL, kC, kR, vdc;
   logic [N-1:0]   S_pwm;
   logic [N*W-1:0] iL, vL;
   logic [W-1:0]   iC, vC, iLoad;
   logic           busy, done, overrun;

   ohs_boost_nphase_l1 #(
      .MODEL_DATA_WIDTH (W),
      .MODEL_Q_WIDTH    (Q),
      .N_PHASES         (N)
   ) dut (
      .aclk    (aclk),
      .reset   (reset),
      .ce      (ce),
      .kL      (kL),
      .kC      (kC),
      .kR      (kR),
      .vdc     (vdc),
      .S_pwm   (S_pwm),
      .iL      (iL),
      .vL      (vL),
      .iC      (iC),
      .vC      (vC),
      .iLoad   (iLoad),
      .busy    (busy),
      .done    (done),
      .overrun (overrun)
   );

   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   typedef struct {
      int             cyc;
      logic [N*W-1:0] il;
      logic [N*W-1:0] vl;
      logic [W-1:0]   ic;
      logic [W-1:0]   vc;
      logic [W-1:0]   iload;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   function automatic logic [N*W-1:0] rep(input logic [W-1:0] v);
      logic [N*W-1:0] r;
      for (int i = 0; i < N; i++) r[i*W +: W] = v;
      return r;
   endfunction

   // monitor: compare every done pulse against the oldest expectation
   always @(negedge aclk) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_cycle", 64'(cyc), 64'(e.cyc));
            for (int i = 0; i < N; i++) begin
               chk($sformatf("iL[%0d]", i), 64'(iL[i*W +: W]), 64'(e.il[i*W +: W]));
               chk($sformatf("vL[%0d]", i), 64'(vL[i*W +: W]), 64'(e.vl[i*W +: W]));
            end
            chk("iC", 64'(iC), 64'(e.ic));
            chk("vC", 64'(vC), 64'(e.vc));
            chk("iLoad", 64'(iLoad), 64'(e.iload));
         end
      end
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // one ce pulse; outputs expected N+3 cycles after the ce cycle
   task automatic issue(input logic [N*W-1:0] il, input logic [N*W-1:0] vl,
                        input logic [W-1:0] ic, input logic [W-1:0] vc,
                        input logic [W-1:0] ild);
      exp_t e;
      e.cyc = cyc + N + 3;
      e.il = il; e.vl = vl; e.ic = ic; e.vc = vc; e.iload = ild;
      sb.push_back(e);
      ce = 1'b1;
      tick();
      ce = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   logic [W-1:0] dcm_il, dcm_vl;

   initial begin
`ifdef OHS_BOOST_DCM_EN
      dcm_il = 32'h0000_0000;
      dcm_vl = 32'h0000_0000;
`else
      dcm_il = 32'hFFFF_5C29;
      dcm_vl = 32'hFFC0_0000;
`endif
      // reset held two cycles with ce asserted
      reset = 1'b1; ce = 1'b1;
      kL = 32'd0; kC = 32'd0; kR = 32'd0; vdc = 32'd0; S_pwm = 4'b0000;
      tick(); tick();
      chk("rst_iL", 64'(iL[63:0]), 64'd0);
      chk("rst_vL", 64'(vL[63:0]), 64'd0);
      chk("rst_iC", 64'(iC), 64'd0);
      chk("rst_vC", 64'(vC), 64'd0);
      chk("rst_iLoad", 64'(iLoad), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_overrun", 64'(overrun), 64'd0);
      ce = 1'b0; reset = 1'b0;
      tick();

      // CCM step, all switches on; kL scrambled after snapshot
      kL = 32'd41943; vdc = 32'h0040_0000; S_pwm = 4'b1111;
      kC = 32'h0040_0000; kR = 32'h0020_0000;
      issue(rep(32'd41943), rep(32'h0040_0000), 32'd0, 32'd0, 32'd0);
      kL = 32'h1234_5678;
      chk("busy_in_step", 64'(busy), 64'd1);
      repeat (N + 3) tick();
      kL = 32'd41943;

      // overrun: second ce 3 cycles into the step is ignored
      issue(rep(32'd83886), rep(32'h0040_0000), 32'd0, 32'd0, 32'd0);
      tick(); tick();
      ce = 1'b1; tick(); ce = 1'b0;
      repeat (10) tick();
      chk("overrun_set", 64'(overrun), 64'd1);
      issue(rep(32'd125829), rep(32'h0040_0000), 32'd0, 32'd0, 32'd0);
      repeat (N + 3) tick();
      chk("overrun_sticky", 64'(overrun), 64'd1);

      // negative input voltage: diode blocking vs bidirectional
      do_reset();
      chk("overrun_cleared", 64'(overrun), 64'd0);
      vdc = 32'hFFC0_0000;
      issue(rep(dcm_il), rep(dcm_vl), 32'd0, 32'd0, 32'd0);
      repeat (N + 3) tick();

      // saturation, two steps
      do_reset();
      kL = 32'h7FFF_FFFF; vdc = 32'h7FFF_FFFF;
      issue(rep(32'h7FFF_FFFF), rep(32'h7FFF_FFFF), 32'd0, 32'd0, 32'd0);
      repeat (N + 3) tick();
      issue(rep(32'h7FFF_FFFF), rep(32'h7FFF_FFFF), 32'd0, 32'd0, 32'd0);
      repeat (N + 3) tick();

      // all switches off, back-to-back steps (second ce on the done cycle)
      do_reset();
      kL = 32'd41943; vdc = 32'h0040_0000; S_pwm = 4'b0000;
      kC = 32'h0040_0000; kR = 32'h0020_0000;
      issue(rep(32'd41943), rep(32'h0040_0000), 32'd167772, 32'd167772, 32'd0);
      repeat (N + 2) tick();
      chk("done_before_b2b", 64'(done), 64'd1);
      issue(rep(32'd82208), rep(32'd4026532), 32'd244946, 32'd412718, 32'd83886);
      repeat (N + 3) tick();
      chk("no_overrun_b2b", 64'(overrun), 64'd0);

      // reset while leg 2 is being stepped
      ce = 1'b1; tick(); ce = 1'b0;
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      chk("midrst_iL0", 64'(iL[W-1:0]), 64'd0);
      chk("midrst_vC", 64'(vC), 64'd0);
      chk("midrst_iC", 64'(iC), 64'd0);
      repeat (12) tick();

      chk("pending_steps", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ohs_boost_nphase_l1.md
Name: ohs_boost_nphase_l1

Overview:
N-phase interleaved boost converter electrical model, the parametrised successor of the single-switch level-1 boost model.
- N inductor legs (own PWM and inductor current each) share one output capacitor and resistive load.
- One time-multiplexed fixed-point multiplier steps the legs sequentially per forward-Euler step, triggered by model clock enable.
- Sits behind the existing AXI4-Lite register block, which supplies kL/kC/kR/vdc and reads back the outputs.

Parameters:
MODEL_DATA_WIDTH, 32, signed two's-complement width W of all model quantities.
MODEL_Q_WIDTH, 22, fractional bits Q (1.0 = 2^Q).
N_PHASES, 4, number of inductor legs, legal 1..8.

Ports:
aclk  in  1  model clock.
reset  in  1  synchronous, active-high reset.
ce  in  1  model clock enable; starts one integration step.
kL  in  W  dt/L, Q format.
kC  in  W  dt/C, Q format.
kR  in  W  1/R, Q format.
vdc  in  W  input voltage, Q format.
S_pwm  in  N_PHASES  switch state per leg; 1 = switch on.
iL  out  N_PHASES*W  packed inductor currents; leg p at bits [p*W +: W].
vL  out  N_PHASES*W  packed inductor voltages.
iC  out  W  capacitor current.
vC  out  W  capacitor (output) voltage.
iLoad  out  W  load current.
busy  out  1  step in progress.
done  out  1  one-cycle pulse; outputs updated this cycle.
overrun  out  1  sticky; ce arrived while busy.

Behaviour:
- Reset: every output, internal leg state, vC state and FSM go to 0 / IDLE on the next edge, including mid-step; the step in flight is discarded and no done pulse is produced.
- FSM states and transitions:
  - IDLE: on ce=1, snapshot S_pwm, kL, kC, kR and vdc; go to PHASE with p=0.
  - PHASE: one cycle per leg p = 0..N_PHASES-1.
    - vL_p = S_p ? vdc : vdc - vC_old.
    - iL_p += mul(kL, vL_p).
    - After leg N_PHASES-1, go to LOAD.
  - LOAD: iLoad = mul(kR, vC_old).
  - CAP: iC = sum of iL_p over legs with S_p=0 (post-update currents) - iLoad; vC += mul(kC, iC); go to IDLE.
- busy = 1 in PHASE, LOAD and CAP.
- done asserts on the cycle after CAP; latency from ce edge to done is N_PHASES+3 cycles.
- vC_old = vC at snapshot; every leg in one step uses the same value.
- mul(a,b): full 2W-bit signed product, arithmetic shift right by Q, saturate to [-2^(W-1), 2^(W-1)-1].
- All additions and subtractions are computed one bit wider and saturated to W bits. The iC sum uses W+4 bits, then saturates.
- Output registers (iL, vL, iC, vC, iLoad) change only together, on the cycle done=1. They hold otherwise.
- ce while busy: ignored (no restart, no double step); overrun set. overrun clears only on reset.
- ce in the same cycle as done/IDLE re-entry: accepted; back-to-back steps are allowed with no gap.
- ce=1 held continuously: one step per N_PHASES+3 cycles, overrun set from the 2nd busy cycle onward.
- Parameter inputs may change at any time; only the values snapshotted at step start are used.

Optional Feature:
Macro OHS_BOOST_DCM_EN.
- Defined: diode-blocking model; after each leg update, iL_p < 0 is clamped to 0 and vL_p is then reported as 0, giving discontinuous conduction.
- Undefined: ideal bidirectional switches, continuous conduction only; iL_p may go negative and no clamp logic is built.

Decomposition:
- Package ohs_boost_pkg holds:
  - FSM state enum (IDLE, PHASE, LOAD, CAP);
  - a phase-index width constant of $clog2(N_PHASES) with a minimum of 1;
  - a Q-format ONE constant helper;
  - a W-bit saturation function.
- One sub-module, ohs_fixmul_sat: combinational signed multiply, shift by Q and saturate. It is instantiated once and shared by all FSM states.

Test Plan:
- Reset: hold reset 2 cycles with ce=1 -> all outputs 0, busy=0, done=0, overrun=0.
- CCM step (N_PHASES=4, Q=22): kL=41943, vdc=0x00400000, S_pwm=4'b1111, one ce pulse -> done exactly 7 cycles later; each iL leg = 41943; vL legs = 0x00400000; iC=0; vC=0.
- Overrun: ce pulse, then ce again 3 cycles later -> a single done after 7 cycles, overrun=1, and overrun remains 1 through later steps until reset.
- DCM: vdc=0xFFC00000 (-1.0), kL=41943, S_pwm=4'b1111, one step -> iL legs = 0 with OHS_BOOST_DCM_EN defined; iL legs = -41943 (0xFFFF5C29) without it.
- Saturation: kL=0x7FFFFFFF, vdc=0x7FFFFFFF, S_pwm all 1, 2 steps -> each iL = 0x7FFFFFFF, no wrap.
- Reset mid-step: assert reset during PHASE p=2 -> next cycle busy=0, all outputs 0, and no done pulse at the original done slot.
